// File: rtl/cache_port_arbiter_if.sv
`timescale 1ns/1ps
// Request/response bundle joining the fetcher, the executer, the arbiter and the cache read port.
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              f_en;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_data;
  logic              x_en;
  logic [ADDR_W-1:0] x_addr;
  logic              x_ack;
  logic [DATA_W-1:0] x_data;
  logic              cache_en;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_do;
  logic              cache_ack;
  logic              busy;
  logic              owner;

  // Arbiter side.
  modport master (
    input  f_en, f_addr, x_en, x_addr, cache_do, cache_ack,
    output f_ack, f_data, x_ack, x_data, cache_en, cache_addr, busy, owner
  );

  // Requesters and cache side.
  modport slave (
    output f_en, f_addr, x_en, x_addr, cache_do, cache_ack,
    input  f_ack, f_data, x_ack, x_data, cache_en, cache_addr, busy, owner
  );
endinterface

// File: rtl/cache_port_arbiter.sv
`timescale 1ns/1ps
// Shares the cache read port between fetcher (F) and executer (X): IDLE -> BUSY -> DONE, all outputs registered.
// Fixed F-over-X priority by default; define CACHE_ARB_ROUND_ROBIN_EN to break ties toward the port not last served.
module cache_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  cache_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   win_x;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_x;

  // A tie goes to whichever port did not complete most recently.
  always_comb win_x = bus.x_en && (!bus.f_en || !last_x);
`else
  always_comb win_x = bus.x_en && !bus.f_en;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bus.cache_en   <= 1'b0;
      bus.cache_addr <= {ADDR_W{1'b0}};
      bus.f_ack      <= 1'b0;
      bus.x_ack      <= 1'b0;
      bus.f_data     <= {DATA_W{1'b0}};
      bus.x_data     <= {DATA_W{1'b0}};
      bus.owner      <= 1'b0;
      bus.busy       <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_x         <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.f_en || bus.x_en) begin
            bus.cache_addr <= win_x ? bus.x_addr : bus.f_addr;
            bus.cache_en   <= 1'b1;
            bus.owner      <= win_x;
            bus.busy       <= 1'b1;
            state          <= BUSY;
          end
        end
        BUSY: begin
          // Address and owner are frozen here; requester inputs are not looked at.
          if (bus.cache_ack) begin
            bus.cache_en <= 1'b0;
            if (bus.owner) begin
              bus.x_data <= bus.cache_do;
              bus.x_ack  <= 1'b1;
            end else begin
              bus.f_data <= bus.cache_do;
              bus.f_ack  <= 1'b1;
            end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_x <= bus.owner;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          // Hold-off cycle: the owner is dropping its request on this edge.
          bus.f_ack <= 1'b0;
          bus.x_ack <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ack_exclusive: assert property (@(posedge clk) disable iff (reset) !(bus.f_ack && bus.x_ack));
  a_en_in_busy:    assert property (@(posedge clk) disable iff (reset) bus.cache_en |-> (state == BUSY));

endmodule

// File: tb/tb_cache_port_arbiter.sv
`timescale 1ns/1ps
// Randomised scoreboard bench: a transaction-level model predicts each grant and completion with its cycle.
module tb_cache_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { int cyc; logic port; logic [ADDR_W-1:0] addr; } grant_t;
  typedef struct { int cyc; logic port; logic [DATA_W-1:0] data; } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state.
  logic              req[2];
  logic [ADDR_W-1:0] raddr[2];
  int                hold_until[2];
  logic [DATA_W-1:0] exp_data[2];
  logic              cur_owner = 1'b0;
  logic              last_x = 1'b1;
  logic [DATA_W-1:0] cur_data = '0;
  int free_edge = 0, ack_cyc = -10, drop_cyc = -10;
  int en_from = 1, en_to = 0, busy_from = 1, busy_to = 0;
  int fixed_l = 0;
  logic [DATA_W-1:0] fixed_data = '0;
  logic use_fixed_data = 1'b0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_values();
    check("rst_cache_en", 64'(bus.cache_en), 64'd0);
    check("rst_cache_addr", 64'(bus.cache_addr), 64'd0);
    check("rst_f_ack", 64'(bus.f_ack), 64'd0);
    check("rst_x_ack", 64'(bus.x_ack), 64'd0);
    check("rst_f_data", 64'(bus.f_data), 64'd0);
    check("rst_x_data", 64'(bus.x_data), 64'd0);
    check("rst_owner", 64'(bus.owner), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; raddr[p] = '0; hold_until[p] = 0; exp_data[p] = '0;
    end
    grant_q.delete(); resp_q.delete();
    last_x = 1'b1; free_edge = 0; ack_cyc = -10; drop_cyc = -10;
    en_from = 1; en_to = 0; busy_from = 1; busy_to = 0;
    bus.f_en = 1'b0; bus.x_en = 1'b0; bus.f_addr = '0; bus.x_addr = '0;
    bus.cache_ack = 1'b0; bus.cache_do = '0;
  endtask

  // One cycle of requesters + cache + model; decisions here are sampled at the next rising edge.
  task automatic step(input int prob);
    logic w, en_o;
    logic [ADDR_W-1:0] addr_o;
    int g, lat;
    @(negedge clk);
    if (cyc == ack_cyc) begin
      bus.cache_ack = 1'b1; bus.cache_do = cur_data;
    end else if (cyc + 1 > busy_to && $urandom_range(0, 7) == 0) begin
      bus.cache_ack = 1'b1; bus.cache_do = $urandom;
    end else begin
      bus.cache_ack = 1'b0; bus.cache_do = $urandom;
    end
    if (cyc == drop_cyc) begin
      req[cur_owner] = 1'b0; hold_until[cur_owner] = cyc + 1;
    end
    for (int p = 0; p < 2; p++)
      if (!req[p] && cyc >= hold_until[p] && $urandom_range(1, 100) <= prob) begin
        req[p] = 1'b1; raddr[p] = ADDR_W'($urandom);
      end
    if (cyc + 1 >= free_edge && (req[0] || req[1])) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      w = req[1] && (!req[0] || !last_x);
`else
      w = req[1] && !req[0];
`endif
      g = cyc + 1;
      lat = (fixed_l != 0) ? fixed_l : int'($urandom_range(1, 4));
      cur_owner = w;
      cur_data = use_fixed_data ? fixed_data : DATA_W'($urandom);
      grant_q.push_back('{g, w, raddr[w]});
      resp_q.push_back('{g + lat, w, cur_data});
      ack_cyc = g + lat - 1; drop_cyc = g + lat; free_edge = g + lat + 2;
      en_from = g; en_to = g + lat - 1; busy_from = g; busy_to = g + lat;
      last_x = w;
    end
    for (int p = 0; p < 2; p++) begin
      en_o = req[p]; addr_o = raddr[p];
      // The owner may misbehave while its access is in flight; the arbiter must not care.
      if (p == int'(cur_owner) && cyc >= busy_from && cyc < busy_to && $urandom_range(0, 3) == 0) begin
        en_o = 1'b0; addr_o = ADDR_W'($urandom);
      end
      if (p == 0) begin bus.f_en = en_o; bus.f_addr = addr_o; end
      else        begin bus.x_en = en_o; bus.x_addr = addr_o; end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a completion.
  initial begin
    logic prev_en;
    logic [ADDR_W-1:0] prev_addr;
    grant_t gr;
    resp_t rs;
    prev_en = 1'b0; prev_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (!mon_en) begin
        prev_en = 1'b0;
      end else begin
        if (bus.cache_en && !prev_en) begin
          if (grant_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_grant: owner %0d addr %0h, no grant expected at cycle %0d", bus.owner, bus.cache_addr, cyc);
          end else begin
            gr = grant_q.pop_front();
            check("grant_cycle", 64'(cyc), 64'(gr.cyc));
            check("grant_owner", 64'(bus.owner), 64'(gr.port));
            check("grant_addr", 64'(bus.cache_addr), 64'(gr.addr));
          end
        end
        if (bus.cache_en && prev_en) check("addr_stable", 64'(bus.cache_addr), 64'(prev_addr));
        if (bus.f_ack || bus.x_ack) begin
          if (bus.f_ack && bus.x_ack) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_both: f_ack and x_ack together, expected at most one at cycle %0d", cyc);
          end else if (resp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ack: f_ack %0d x_ack %0d, no completion expected at cycle %0d", bus.f_ack, bus.x_ack, cyc);
          end else begin
            rs = resp_q.pop_front();
            check("ack_cycle", 64'(cyc), 64'(rs.cyc));
            check("ack_port", 64'(bus.x_ack), 64'(rs.port));
            exp_data[rs.port] = rs.data;
          end
        end
        check("f_data", 64'(bus.f_data), 64'(exp_data[0]));
        check("x_data", 64'(bus.x_data), 64'(exp_data[1]));
        check("cache_en", 64'(bus.cache_en), 64'(cyc >= en_from && cyc <= en_to));
        check("busy", 64'(bus.busy), 64'(cyc >= busy_from && cyc <= busy_to));
        prev_en = bus.cache_en; prev_addr = bus.cache_addr;
      end
    end
  end

  initial begin
    model_clear();
    #1 reset = 1'b1;
    #2 check_reset_values();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    free_edge = cyc + 1;

    // Single F request, cache answers two cycles after cache_en.
    req[0] = 1'b1; raddr[0] = 16'h0010;
    fixed_l = 2; use_fixed_data = 1'b1; fixed_data = 32'hDEADBEEF;
    repeat (8) step(0);
    use_fixed_data = 1'b0;

    // Simultaneous F and X, immediate cache answer.
    req[0] = 1'b1; raddr[0] = 16'h0001;
    req[1] = 1'b1; raddr[1] = 16'h0002;
    fixed_l = 1;
    repeat (12) step(0);

    fixed_l = 0;
    repeat (1500) step(30);
    // Both requesters saturating: starvation (fixed) or alternation (round robin).
    repeat (200) step(100);
    repeat (20) step(0);

    // Reset while an access is in flight.
    req[0] = 1'b1; raddr[0] = 16'h0BAD; fixed_l = 4;
    step(0);
    step(0);
    mon_en = 1'b0;
    check("busy_before_reset", 64'(bus.cache_en), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_values();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    free_edge = cyc + 1;
    mon_en = 1'b1;

    req[0] = 1'b1; raddr[0] = 16'h0100;
    req[1] = 1'b1; raddr[1] = 16'h0200;
    fixed_l = 1;
    repeat (12) step(0);
    fixed_l = 0;
    repeat (400) step(40);
    repeat (20) step(0);

    check("grants_left", 64'(grant_q.size()), 64'd0);
    check("acks_left", 64'(resp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
